// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: button conditioning, run/pause/lap/clear FSM and
// display mux for the counter block.
// Optional macro STOPWATCH_CTRL_DEBOUNCE_EN inserts a per-button counter filter
// of DEBOUNCE_CYCLES stable cycles after the synchronizers.
module stopwatch_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        btn_start_stop,
    input  logic        btn_lap,
    input  logic        btn_clear,
    input  logic [17:0] epoch,
    input  logic [9:0]  m_epoch,
    output logic        run,
    output logic        sw_reset,
    output logic [17:0] disp_epoch,
    output logic [9:0]  disp_m_epoch,
    output logic        lap_valid,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StRunning = 2'd1,
        StPaused  = 2'd2,
        StLap     = 2'd3
    } state_e;

    // Bit 0 = start/stop, bit 1 = lap, bit 2 = clear.
    logic [2:0] btn_raw;
    logic [2:0] sync1_q, sync2_q;
    logic [2:0] level;
    logic [2:0] prev_q, prev_d;
    logic [2:0] arm_q, arm_d;
    logic [1:0] warm_q, warm_d;
    logic [2:0] press;

    state_e      state_q, state_d;
    logic        run_q, run_d;
    logic        sw_reset_q, sw_reset_d;
    logic        lap_valid_q, lap_valid_d;
    logic [17:0] lap_epoch_q, lap_epoch_d;
    logic [9:0]  lap_m_epoch_q, lap_m_epoch_d;
    logic [17:0] disp_epoch_q, disp_epoch_d;
    logic [9:0]  disp_m_epoch_q, disp_m_epoch_d;

    assign btn_raw = {btn_clear, btn_lap, btn_start_stop};

    // Two-flop synchronizers for the asynchronous buttons.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

`ifdef STOPWATCH_CTRL_DEBOUNCE_EN
    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic [2:0][CntW-1:0] cnt_q, cnt_d;
    logic [2:0]           filt_q, filt_d;

    // Filtered level flips only after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        for (int i = 0; i < 3; i++) begin
            if (sync2_q[i] != filt_q[i]) begin
                if (cnt_q[i] == CntMax) begin
                    filt_d[i] = ~filt_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Debounce counter and filtered level registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            filt_q <= '0;
            cnt_q  <= '0;
        end else begin
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign level = filt_q;
`else
    logic unused_debounce;
    assign unused_debounce = (DEBOUNCE_CYCLES == 0);
    assign level = sync2_q;
`endif

    // Edge detect; a button is armed only once a genuine released level has
    // passed the synchronizers, so a button held through reset never presses.
    always_comb begin
        prev_d = level;
        warm_d = (warm_q == 2'd2) ? 2'd2 : warm_q + 2'd1;
        arm_d  = arm_q | ({3{warm_q == 2'd2}} & ~sync2_q);
        press  = level & ~prev_q & arm_q;
    end

    // Edge-detect and arming registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            prev_q <= '0;
            arm_q  <= '0;
            warm_q <= '0;
        end else begin
            prev_q <= prev_d;
            arm_q  <= arm_d;
            warm_q <= warm_d;
        end
    end

    // Next state and registered outputs; clear outranks start/stop outranks lap.
    always_comb begin
        state_d       = state_q;
        sw_reset_d    = 1'b0;
        lap_epoch_d   = lap_epoch_q;
        lap_m_epoch_d = lap_m_epoch_q;
        unique case (state_q)
            StIdle: begin
                if (press[2]) begin
                    sw_reset_d = 1'b1;
                end else if (press[0]) begin
                    state_d = StRunning;
                end
            end
            StRunning: begin
                if (!press[2]) begin
                    if (press[0]) begin
                        state_d = StPaused;
                    end else if (press[1]) begin
                        state_d       = StLap;
                        lap_epoch_d   = epoch;
                        lap_m_epoch_d = m_epoch;
                    end
                end
            end
            StLap: begin
                if (!press[2]) begin
                    if (press[0]) begin
                        state_d = StPaused;
                    end else if (press[1]) begin
                        state_d = StRunning;
                    end
                end
            end
            StPaused: begin
                if (press[2]) begin
                    state_d    = StIdle;
                    sw_reset_d = 1'b1;
                end else if (press[0]) begin
                    state_d = StRunning;
                end
            end
            default: state_d = StIdle;
        endcase
        run_d          = (state_d == StRunning) || (state_d == StLap);
        lap_valid_d    = (state_d == StLap);
        disp_epoch_d   = lap_valid_d ? lap_epoch_d : epoch;
        disp_m_epoch_d = lap_valid_d ? lap_m_epoch_d : m_epoch;
    end

    // State and output registers; reset also requests a counter clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= StIdle;
            run_q          <= 1'b0;
            sw_reset_q     <= 1'b1;
            lap_valid_q    <= 1'b0;
            lap_epoch_q    <= '0;
            lap_m_epoch_q  <= '0;
            disp_epoch_q   <= '0;
            disp_m_epoch_q <= '0;
        end else begin
            state_q        <= state_d;
            run_q          <= run_d;
            sw_reset_q     <= sw_reset_d;
            lap_valid_q    <= lap_valid_d;
            lap_epoch_q    <= lap_epoch_d;
            lap_m_epoch_q  <= lap_m_epoch_d;
            disp_epoch_q   <= disp_epoch_d;
            disp_m_epoch_q <= disp_m_epoch_d;
        end
    end

    assign state        = state_q;
    assign run          = run_q;
    assign sw_reset     = sw_reset_q;
    assign lap_valid    = lap_valid_q;
    assign disp_epoch   = disp_epoch_q;
    assign disp_m_epoch = disp_m_epoch_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios with literal expectations plus a
// randomized phase, all cross-checked every cycle against a history-based model.
module tb_stopwatch_ctrl;

    localparam int unsigned Db = 4;
`ifdef STOPWATCH_CTRL_DEBOUNCE_EN
    localparam bit DbEn = 1'b1;
`else
    localparam bit DbEn = 1'b0;
`endif
    localparam int Lat     = DbEn ? int'(Db) + 2 : 2;
    localparam int Hold    = DbEn ? int'(Db) + 6 : 1;
    localparam int Gap     = DbEn ? 3 * int'(Db) + 10 : 4;
    localparam int MaxHold = DbEn ? 3 * int'(Db) : 6;
    localparam int MaxC    = 8192;
    localparam int Inf     = 32'h3fff_ffff;

    logic        clock, reset;
    logic        btn_start_stop, btn_lap, btn_clear;
    logic [17:0] epoch;
    logic [9:0]  m_epoch;
    logic        run, sw_reset, lap_valid;
    logic [17:0] disp_epoch;
    logic [9:0]  disp_m_epoch;
    logic [1:0]  state;

    stopwatch_ctrl #(.DEBOUNCE_CYCLES(Db)) dut (
        .clock          (clock),
        .reset          (reset),
        .btn_start_stop (btn_start_stop),
        .btn_lap        (btn_lap),
        .btn_clear      (btn_clear),
        .epoch          (epoch),
        .m_epoch        (m_epoch),
        .run            (run),
        .sw_reset       (sw_reset),
        .disp_epoch     (disp_epoch),
        .disp_m_epoch   (disp_m_epoch),
        .lap_valid      (lap_valid),
        .state          (state)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endfunction

    // ---------------- behavioural model ----------------
    // Histories indexed by clock edge: raw button sample, synchronized level,
    // filtered level. A press is a 0->1 step of the filtered level, valid only
    // once the button has been seen released since the last reset.
    bit          raw_h  [3][MaxC];
    bit          sync_h [3][MaxC];
    bit          filt_h [3][MaxC];
    int          first_zero [3];
    int          last_rst = 0;
    int          cyc = 0;
    int          e;
    bit          pr [3];
    bit          fl, flip;
    int          m_state = 0;
    bit          m_run = 1'b0, m_swr = 1'b0, m_lv = 1'b0;
    logic [17:0] m_lap_e = '0, m_disp_e = '0;
    logic [9:0]  m_lap_m = '0, m_disp_m = '0;

    always @(posedge clock) begin
        e = cyc;
        if (e >= MaxC) begin
            n_fail++;
            $display("FAIL model_capacity: cycle %0d beyond %0d", e, MaxC);
            $fatal(1);
        end
        raw_h[0][e] = btn_start_stop;
        raw_h[1][e] = btn_lap;
        raw_h[2][e] = btn_clear;
        if (reset) begin
            last_rst = e;
            for (int i = 0; i < 3; i++) begin
                first_zero[i] = Inf;
                sync_h[i][e]  = 1'b0;
                filt_h[i][e]  = 1'b0;
            end
            m_state  = 0;
            m_run    = 1'b0;
            m_swr    = 1'b1;
            m_lv     = 1'b0;
            m_lap_e  = '0;
            m_lap_m  = '0;
            m_disp_e = '0;
            m_disp_m = '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (first_zero[i] == Inf && !raw_h[i][e]) first_zero[i] = e;
                sync_h[i][e] = (e - last_rst >= 2) ? raw_h[i][e-1] : 1'b0;
                if (DbEn) begin
                    fl   = filt_h[i][e-1];
                    flip = (e >= int'(Db));
                    for (int k = 1; k <= int'(Db); k++) begin
                        if (flip && sync_h[i][e-k] == fl) flip = 1'b0;
                    end
                    filt_h[i][e] = flip ? ~fl : fl;
                end else begin
                    filt_h[i][e] = sync_h[i][e];
                end
                pr[i] = filt_h[i][e-1] && !filt_h[i][e-2] && (first_zero[i] <= e - 3);
            end
            m_swr = 1'b0;
            if (pr[2]) begin
                if (m_state == 0) m_swr = 1'b1;
                else if (m_state == 2) begin
                    m_state = 0;
                    m_swr   = 1'b1;
                end
            end else if (pr[0]) begin
                m_state = (m_state == 1 || m_state == 3) ? 2 : 1;
            end else if (pr[1]) begin
                if (m_state == 1) begin
                    m_state = 3;
                    m_lap_e = epoch;
                    m_lap_m = m_epoch;
                end else if (m_state == 3) begin
                    m_state = 1;
                end
            end
            m_run    = (m_state == 1 || m_state == 3);
            m_lv     = (m_state == 3);
            m_disp_e = m_lv ? m_lap_e : epoch;
            m_disp_m = m_lv ? m_lap_m : m_epoch;
        end
        cyc++;
        #1;
        chk("model_state", int'(state), m_state);
        chk("model_run", int'(run), int'(m_run));
        chk("model_sw_reset", int'(sw_reset), int'(m_swr));
        chk("model_lap_valid", int'(lap_valid), int'(m_lv));
        chk("model_disp_epoch", int'(disp_epoch), int'(m_disp_e));
        chk("model_disp_m_epoch", int'(disp_m_epoch), int'(m_disp_m));
    end

    // ---------------- directed helpers ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic press(input bit ss, input bit lp, input bit clr, input int pre,
                         input int post, input bit swr, input string tag);
        @(negedge clock);
        btn_start_stop = ss;
        btn_lap        = lp;
        btn_clear      = clr;
        fork
            begin
                repeat (Hold) @(negedge clock);
                btn_start_stop = 1'b0;
                btn_lap        = 1'b0;
                btn_clear      = 1'b0;
            end
        join_none
        repeat (Lat) @(posedge clock);
        #1 chk({tag, "_before"}, int'(state), pre);
        @(posedge clock);
        #1 chk({tag, "_state"}, int'(state), post);
        chk({tag, "_run"}, int'(run), (post == 1 || post == 3) ? 1 : 0);
        chk({tag, "_sw_reset"}, int'(sw_reset), int'(swr));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    int  hold_cnt [3];
    bit  lvl [3];

    initial begin
        reset          = 1'b1;
        btn_start_stop = 1'b1;  // held across reset release
        btn_lap        = 1'b0;
        btn_clear      = 1'b0;
        epoch          = 18'h12345;
        m_epoch        = 10'd77;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_state", int'(state), 0);
        chk("reset_sw_reset", int'(sw_reset), 1);
        chk("reset_run", int'(run), 0);
        chk("reset_lap_valid", int'(lap_valid), 0);
        chk("reset_disp_epoch", int'(disp_epoch), 0);
        chk("reset_disp_m_epoch", int'(disp_m_epoch), 0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1 chk("release_sw_reset", int'(sw_reset), 0);
        repeat (Lat + int'(Db) + 4) @(posedge clock);
        #1 chk("held_through_reset_state", int'(state), 0);
        @(negedge clock);
        btn_start_stop = 1'b0;
        idle(Gap);

        press(1, 0, 0, 0, 1, 0, "start");
        idle(Gap);

        @(negedge clock);
        epoch   = 18'h0_41_05;
        m_epoch = 10'd123;
        press(0, 1, 0, 1, 3, 0, "lap_take");
        chk("lap_valid_on", int'(lap_valid), 1);
        chk("lap_disp_epoch", int'(disp_epoch), 18'h0_41_05);
        chk("lap_disp_m_epoch", int'(disp_m_epoch), 123);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            epoch   = 18'($urandom);
            m_epoch = 10'($urandom);
            @(posedge clock);
            #1;
            chk("lap_hold_epoch", int'(disp_epoch), 18'h0_41_05);
            chk("lap_hold_m_epoch", int'(disp_m_epoch), 123);
        end
        idle(Gap);
        press(0, 1, 0, 3, 1, 0, "lap_release");
        chk("lap_valid_off", int'(lap_valid), 0);
        chk("live_disp_epoch", int'(disp_epoch), int'(epoch));
        chk("live_disp_m_epoch", int'(disp_m_epoch), int'(m_epoch));
        idle(Gap);

        press(1, 0, 0, 1, 2, 0, "pause");
        idle(Gap);
        press(0, 0, 1, 2, 0, 1, "clear_paused");
        @(posedge clock);
        #1 chk("clear_pulse_end", int'(sw_reset), 0);
        idle(Gap);
        press(1, 0, 0, 0, 1, 0, "restart");
        idle(Gap);
        press(0, 0, 1, 1, 1, 0, "clear_running");
        idle(Gap);
        press(1, 1, 0, 1, 2, 0, "ss_lap_same_cycle");
        idle(Gap);
        press(1, 0, 1, 2, 0, 1, "clear_ss_paused");
        idle(Gap);
        press(0, 0, 1, 0, 0, 1, "clear_idle");
        idle(Gap);

`ifdef STOPWATCH_CTRL_DEBOUNCE_EN
        @(negedge clock);
        btn_start_stop = 1'b1;
        idle(3);
        btn_start_stop = 1'b0;
        repeat (Lat + 6) @(posedge clock);
        #1 chk("glitch_ignored", int'(state), 0);
        idle(Gap);
        press(1, 0, 0, 0, 1, 0, "db_clean");
        repeat (10) @(posedge clock);
        #1 chk("db_single_transition", int'(state), 1);
        idle(Gap);
`endif

        for (int i = 0; i < 3; i++) begin
            hold_cnt[i] = 0;
            lvl[i]      = 1'b0;
        end
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            for (int i = 0; i < 3; i++) begin
                if (hold_cnt[i] == 0) begin
                    lvl[i]      = ~lvl[i];
                    hold_cnt[i] = int'($urandom_range(1, MaxHold));
                end
                hold_cnt[i]--;
            end
            btn_start_stop = lvl[0];
            btn_lap        = lvl[1];
            btn_clear      = lvl[2];
            if ($urandom_range(0, 3) == 0) begin
                epoch   = 18'($urandom);
                m_epoch = 10'($urandom);
            end
            reset = ($urandom_range(0, 299) == 0);
        end
        @(negedge clock);
        reset          = 1'b0;
        btn_start_stop = 1'b0;
        btn_lap        = 1'b0;
        btn_clear      = 1'b0;
        idle(Gap);
        @(posedge clock);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
